// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, {Z,N,C,V} flag bit positions and
// the flag vector type. Used by the ALU, the result stage and later stages.
package alu_pkg;

  localparam int FLAG_W = 4;

  // out_flags layout is {Z,N,C,V}
  localparam int FLG_V = 0;
  localparam int FLG_C = 1;
  localparam int FLG_N = 2;
  localparam int FLG_Z = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/alu4_result_stage_if.sv
// Stream bundle between the ALU, the result stage and its consumer.
//   in_*  : ALU result + operands + opcode, valid/ready
//   out_* : data, opcode, {Z,N,C,V} flags, valid/ready
// master = environment (drives inputs, consumes outputs), slave = result stage.
interface alu4_result_stage_if #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W:0]           in_result;
  logic [OP_W-1:0]           in_op;
  logic [DATA_W-1:0]         in_a;
  logic [DATA_W-1:0]         in_b;

  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic [OP_W-1:0]           out_op;
  logic [alu_pkg::FLAG_W-1:0] out_flags;

  modport master (
    output in_valid, in_result, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_op, out_flags
  );

  modport slave (
    input  in_valid, in_result, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_op, out_flags
  );
endinterface

// File: rtl/alu_skid_buf.sv
// Generic 2-entry valid/ready skid buffer, full throughput.
//   in_valid/in_ready/in_data   : upstream side; in_ready is the inverted skid-full flop
//   out_valid/out_ready/out_data: downstream side, driven straight from the output register
// An entry accepted while the output register is stalled parks in the skid
// register; the skid entry moves forward on the cycle the output drains.
module alu_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_vld;
  logic [W-1:0] skid_data;
  logic         in_fire;
  logic         out_fire;

  assign in_ready = ~skid_vld;
  assign in_fire  = in_valid & ~skid_vld;
  assign out_fire = out_valid & out_ready;

  // skid_vld implies out_valid, so the "output free" branch only sees a full
  // skid when the output is draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
    end else if (!out_valid || out_fire) begin
      if (skid_vld) begin
        out_data <= skid_data;
        skid_vld <= 1'b0;
      end else if (in_fire) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_data <= in_data;
      skid_vld  <= 1'b1;
    end
  end

endmodule

// File: rtl/alu4_result_stage.sv
// Registered result stage behind the combinational ALU. Derives {Z,N,C,V}
// at capture, buffers through a 2-entry skid buffer, counts output
// handshakes and (optionally) keeps sticky carry/overflow.
//   clk, rst_n      : clock, async active-low reset
//   bus (slave)     : in_* ALU result stream, out_* flagged result stream
//   res_count       : output handshakes since reset, wraps
//   sticky_clr      : clear sticky bits (set wins on the same cycle)
//   sticky_c/_v     : sticky carry/overflow
// Optional feature macro: ALU_RES_STICKY_EN (sticky logic present when
// defined; otherwise sticky_* tie to 0 and sticky_clr is ignored).
module alu4_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  alu4_result_stage_if.slave bus,
  output logic [CNT_W-1:0]  res_count,
  input  logic              sticky_clr,
  output logic              sticky_c,
  output logic              sticky_v
);

  localparam int M = DATA_W - 1;

  typedef struct packed {
    flags_t            flags;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              in_ent;
  ent_t              out_ent;
  logic [DATA_W-1:0] d;
  logic              out_fire;

  // Flag derivation on the incoming ALU result. C/V only mean something for
  // the arithmetic and shift ops; NOT sets r[DATA_W] by extension, so C is
  // taken from the opcode, never blindly from r[DATA_W].
  always_comb begin
    d               = bus.in_result[DATA_W-1:0];
    in_ent          = '0;
    in_ent.data     = d;
    in_ent.op       = bus.in_op;
    in_ent.flags[FLG_Z] = (d == '0);
    in_ent.flags[FLG_N] = d[M];
    case (bus.in_op)
      OP_W'(OP_ADD): begin
        in_ent.flags[FLG_C] = bus.in_result[DATA_W];
        in_ent.flags[FLG_V] = (bus.in_a[M] == bus.in_b[M]) && (d[M] != bus.in_a[M]);
      end
      OP_W'(OP_SUB): begin
        in_ent.flags[FLG_C] = bus.in_result[DATA_W];
        in_ent.flags[FLG_V] = (bus.in_a[M] != bus.in_b[M]) && (d[M] != bus.in_a[M]);
      end
      OP_W'(OP_SHL): in_ent.flags[FLG_C] = bus.in_result[DATA_W];
      OP_W'(OP_SHR): in_ent.flags[FLG_C] = bus.in_a[0];
      default: ;
    endcase
  end

  alu_skid_buf #(.W($bits(ent_t))) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .in_data  (in_ent),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .out_data (out_ent)
  );

  assign bus.out_data  = out_ent.data;
  assign bus.out_op    = out_ent.op;
  assign bus.out_flags = out_ent.flags;
  assign out_fire      = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        res_count <= '0;
    else if (out_fire) res_count <= res_count + CNT_W'(1);
  end

`ifdef ALU_RES_STICKY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_c <= 1'b0;
      sticky_v <= 1'b0;
    end else begin
      if (out_fire && out_ent.flags[FLG_C]) sticky_c <= 1'b1;
      else if (sticky_clr)                  sticky_c <= 1'b0;
      if (out_fire && out_ent.flags[FLG_V]) sticky_v <= 1'b1;
      else if (sticky_clr)                  sticky_v <= 1'b0;
    end
  end
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky_c = 1'b0;
  assign sticky_v = 1'b0;
`endif

endmodule

// File: tb/tb_alu4_result_stage.sv
// Bench for alu4_result_stage: directed flag vectors, stall/skid, sticky,
// randomized traffic and mid-stream reset, all checked against a queue model
// whose flags come from plain integer arithmetic on the operands.
module tb_alu4_result_stage;
  import alu_pkg::*;

`ifdef ALU_RES_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sticky_clr = 1'b0;
  logic [7:0] res_count;
  logic       sticky_c, sticky_v;

  alu4_result_stage_if #(.DATA_W(4), .OP_W(3)) bus ();

  alu4_result_stage #(.DATA_W(4), .OP_W(3), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .res_count (res_count),
    .sticky_clr(sticky_clr),
    .sticky_c  (sticky_c),
    .sticky_v  (sticky_v)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic [2:0] op;
    logic [3:0] flags;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned m_cnt = 0;
  bit          m_sc = 1'b0;
  bit          m_sv = 1'b0;

  function automatic logic [4:0] alu_ref(logic [2:0] op, logic [3:0] a, logic [3:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b1, ~a};
      3'd6:    return {a, 1'b0};
      default: return {2'b00, a[3:1]};
    endcase
  endfunction

  function automatic int s4(logic [3:0] x);
    return (int'(x) >= 8) ? int'(x) - 16 : int'(x);
  endfunction

  function automatic exp_t model(logic [2:0] op, logic [3:0] a, logic [3:0] b);
    exp_t       e;
    logic [4:0] r;
    bit         z, n, c, v;
    int         s;
    r = alu_ref(op, a, b);
    e.data = r[3:0];
    e.op   = op;
    z = (int'(e.data) == 0);
    n = (int'(e.data) >= 8);
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin c = (int'(a) + int'(b) > 15); s = s4(a) + s4(b); v = (s > 7 || s < -8); end
      3'd1: begin c = (int'(a) < int'(b));      s = s4(a) - s4(b); v = (s > 7 || s < -8); end
      3'd6: c = (int'(a) >= 8);
      3'd7: c = (int'(a) % 2 == 1);
      default: ;
    endcase
    e.flags = {z, n, c, v};
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic [2:0] op, logic [3:0] a, logic [3:0] b);
    bus.in_op     = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_result = alu_ref(op, a, b);
  endtask

  // One clock: check every output against the model at the falling edge,
  // then advance the model by the handshakes that happen at the next rise.
  task automatic cycle();
    bit   ia, oa;
    exp_t e;
    @(negedge clk);
    chk("in_ready", bus.in_ready, q.size() < 2);
    chk("out_valid", bus.out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("out_data", bus.out_data, q[0].data);
      chk("out_op", bus.out_op, q[0].op);
      chk("out_flags", bus.out_flags, q[0].flags);
    end
    chk("res_count", res_count, m_cnt);
    chk("sticky_c", sticky_c, m_sc);
    chk("sticky_v", sticky_v, m_sv);
    ia = bus.in_valid && (q.size() < 2);
    oa = bus.out_ready && (q.size() > 0);
    if (oa) begin
      e = q.pop_front();
      m_cnt = (m_cnt + 1) % 256;
    end
    if (STK) begin
      if (oa && e.flags[1]) m_sc = 1'b1;
      else if (sticky_clr)  m_sc = 1'b0;
      if (oa && e.flags[0]) m_sv = 1'b1;
      else if (sticky_clr)  m_sv = 1'b0;
    end
    if (ia) q.push_back(model(bus.in_op, bus.in_a, bus.in_b));
    @(posedge clk);
    #1;
  endtask

  task automatic send_dir(string tag, logic [2:0] op, logic [3:0] a, logic [3:0] b,
                          logic [3:0] xd, logic [3:0] xf);
    drive(op, a, b);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    chk({tag, "_data"}, bus.out_data, xd);
    chk({tag, "_flags"}, bus.out_flags, xf);
    cycle();
  endtask

  task automatic check_reset(string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_out_op"}, bus.out_op, 0);
    chk({tag, "_out_flags"}, bus.out_flags, 0);
    chk({tag, "_res_count"}, res_count, 0);
    chk({tag, "_sticky_c"}, sticky_c, 0);
    chk({tag, "_sticky_v"}, sticky_v, 0);
  endtask

  task automatic rand_run(int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      sticky_clr    = ($urandom_range(0, 15) == 0);
      drive(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      cycle();
    end
    bus.in_valid = 1'b0;
    sticky_clr   = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(3'd0, 4'd0, 4'd0);

    // power-on reset
    @(posedge clk);
    #1;
    check_reset("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed flag vectors: {Z,N,C,V}
    send_dir("add_7_1",  3'b000, 4'd7,  4'd1, 4'd8,  4'b0101);
    send_dir("add_15_1", 3'b000, 4'd15, 4'd1, 4'd0,  4'b1010);
    send_dir("sub_3_5",  3'b001, 4'd3,  4'd5, 4'd14, 4'b0110);
    send_dir("not_0",    3'b101, 4'd0,  4'd0, 4'd15, 4'b0100);
    send_dir("shr_3",    3'b111, 4'd3,  4'd0, 4'd1,  4'b0010);
    send_dir("shl_9",    3'b110, 4'd9,  4'd0, 4'd2,  4'b0010);

    // stall: 3 cycles of in_valid with out_ready low -> 2 held, in_ready low
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      cycle();
    end
    chk("stall_in_ready", bus.in_ready, 0);
    chk("stall_out_valid", bus.out_valid, 1);
    // release with input still streaming: one result per cycle
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      cycle();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // sticky: start clean
    sticky_clr = 1'b1;
    cycle();
    sticky_clr = 1'b0;
    send_dir("stk_add", 3'b000, 4'd7, 4'd1, 4'd8, 4'b0101);
    chk("stk_v_set", sticky_v, STK);
    // clear in the same cycle as another V drain: set wins
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive(3'b000, 4'd7, 4'd1);
    cycle();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    sticky_clr    = 1'b1;
    cycle();
    sticky_clr = 1'b0;
    chk("stk_v_setclr", sticky_v, STK);
    sticky_clr = 1'b1;
    cycle();
    sticky_clr = 1'b0;
    chk("stk_v_clr", sticky_v, 0);
    chk("stk_c_clr", sticky_c, 0);

    // random traffic, long enough for res_count to wrap
    rand_run(1500);

    // mid-stream reset with output and skid both full
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      cycle();
    end
    chk("pre_rst_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("mid");
    q.delete();
    m_cnt = 0;
    m_sc  = 1'b0;
    m_sv  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rand_run(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
